// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator: one shared frame counter, per-channel
// targets with optional slew limiting, applied only at frame boundaries.
module servo_pwm_multi #(
    parameter int NCH        = 4,
    parameter int POS_W      = 8,
    parameter int PERIOD_CYC = 240000,
    parameter int MIN_CYC    = 6000,
    parameter int STEP_CYC   = 94,
    parameter int SLEW       = 0,
    parameter int INIT_POS   = 128,
    localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [CH_W-1:0]      wr_ch,
    input  logic [POS_W-1:0]     wr_pos,
    input  logic [NCH-1:0]       ch_en,
    output logic [NCH-1:0]       servo,
    output logic                 frame_start,
    output logic [NCH-1:0]       settled,
    output logic [NCH*POS_W-1:0] cur_pos
);

    localparam int CTR_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam longint MAX_WIDTH = longint'(MIN_CYC)
                                 + ((longint'(1) << POS_W) - 1) * longint'(STEP_CYC);
    localparam logic [CTR_W-1:0] LAST_CTR = CTR_W'(PERIOD_CYC - 1);

    generate
        if (MAX_WIDTH >= longint'(PERIOD_CYC)) begin : g_width_check
            $error("servo_pwm_multi: widest pulse does not fit inside the frame");
        end
        if (NCH < 1 || NCH > 16) begin : g_nch_check
            $error("servo_pwm_multi: NCH must be 1..16");
        end
    endgenerate

    logic [CTR_W-1:0] ctr_q, ctr_d;
    logic             boundary;
    logic [NCH-1:0]   servo_q, servo_d;
    logic             frame_start_q;

    assign boundary = (ctr_q == LAST_CTR);

    always_comb begin
        ctr_d = boundary ? '0 : ctr_q + CTR_W'(1);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [POS_W-1:0] target_q, target_d;
            logic [POS_W-1:0] current_q, current_d;
            logic [POS_W-1:0] diff;
            logic             en_q, en_d;
            logic [CTR_W-1:0] width_ch;

            always_comb begin
                target_d = target_q;
                if (wr_en && (wr_ch == CH_W'(gi))) begin
                    target_d = wr_pos;
                end
            end

            // Boundary update reads the pre-write target, so a same-clock write waits a frame.
            always_comb begin
                current_d = current_q;
                diff = (target_q > current_q) ? (target_q - current_q) : (current_q - target_q);
                if (boundary) begin
                    if ((SLEW == 0) || (32'(diff) <= SLEW)) begin
                        current_d = target_q;
                    end else if (target_q > current_q) begin
                        current_d = current_q + POS_W'(SLEW);
                    end else begin
                        current_d = current_q - POS_W'(SLEW);
                    end
                end
            end

            always_comb begin
                en_d = boundary ? ch_en[gi] : en_q;
            end

            assign width_ch = CTR_W'(MIN_CYC) + CTR_W'(current_q) * CTR_W'(STEP_CYC);
            assign servo_d[gi] = en_q && (ctr_q < width_ch);
            assign settled[gi] = (current_q == target_q);
            assign cur_pos[gi*POS_W +: POS_W] = current_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    target_q  <= POS_W'(INIT_POS);
                    current_q <= POS_W'(INIT_POS);
                    en_q      <= 1'b0;
                end else begin
                    target_q  <= target_d;
                    current_q <= current_d;
                    en_q      <= en_d;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            ctr_q         <= '0;
            servo_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            ctr_q         <= ctr_d;
            servo_q       <= servo_d;
            frame_start_q <= (ctr_q == '0);
        end
    end

    assign servo       = servo_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: an unlimited-slew and a slew-16 instance share stimulus
// and are checked every cycle against a frame-level reference model.
module tb_servo_pwm_multi;

    localparam int NCH    = 5;
    localparam int POS_W  = 8;
    localparam int P      = 1500;
    localparam int MINC   = 100;
    localparam int STEPC  = 5;
    localparam int INIT   = 128;
    localparam int SLEW_B = 16;
    localparam int CH_W   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, wr_en;
    logic [CH_W-1:0]      wr_ch;
    logic [POS_W-1:0]     wr_pos;
    logic [NCH-1:0]       ch_en;
    logic [NCH-1:0]       servo_a, servo_b, settled_a, settled_b;
    logic                 fs_a, fs_b;
    logic [NCH*POS_W-1:0] cur_a, cur_b;

    servo_pwm_multi #(.NCH(NCH), .POS_W(POS_W), .PERIOD_CYC(P), .MIN_CYC(MINC),
                      .STEP_CYC(STEPC), .SLEW(0), .INIT_POS(INIT)) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_pos(wr_pos),
        .ch_en(ch_en), .servo(servo_a), .frame_start(fs_a), .settled(settled_a),
        .cur_pos(cur_a));

    servo_pwm_multi #(.NCH(NCH), .POS_W(POS_W), .PERIOD_CYC(P), .MIN_CYC(MINC),
                      .STEP_CYC(STEPC), .SLEW(SLEW_B), .INIT_POS(INIT)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_pos(wr_pos),
        .ch_en(ch_en), .servo(servo_b), .frame_start(fs_b), .settled(settled_b),
        .cur_pos(cur_b));

    int n_checks = 0;
    int n_err    = 0;
    int k        = 0;   // non-reset clock edges since reset release
    int tgt_m[NCH], cur_am[NCH], cur_bm[NCH];
    bit en_m[NCH];
    int hi_len_a[NCH], last_len_a[NCH], hi_len_b[NCH], last_len_b[NCH];

    function automatic int wid(input int p);
        return MINC + p * STEPC;
    endfunction

    function automatic int slew_to(input int cur, input int tgt, input int s);
        int d;
        if (s == 0) return tgt;
        d = (tgt > cur) ? tgt - cur : cur - tgt;
        if (d > s) d = s;
        return (tgt > cur) ? cur + d : cur - d;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            if (n_err <= 30)
                $error("FAIL %s at k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // One clock: predict this edge's outputs from the model, advance the model, compare.
    task automatic step();
        int c, wc, wp;
        bit r, we;
        logic [NCH-1:0] ce, es_a, es_b, set_a, set_b;
        logic [NCH*POS_W-1:0] cp_a, cp_b;
        logic efs;
        c = k % P; r = rst; we = wr_en; wc = int'(wr_ch); wp = int'(wr_pos); ce = ch_en;
        @(negedge clk);
        es_a = '0; es_b = '0; efs = 1'b0;
        if (r) begin
            for (int i = 0; i < NCH; i++) begin
                tgt_m[i] = INIT; cur_am[i] = INIT; cur_bm[i] = INIT; en_m[i] = 1'b0;
                hi_len_a[i] = 0; last_len_a[i] = 0; hi_len_b[i] = 0; last_len_b[i] = 0;
            end
            k = 0;
        end else begin
            efs = (c == 0);
            for (int i = 0; i < NCH; i++) begin
                es_a[i] = en_m[i] && (c < wid(cur_am[i]));
                es_b[i] = en_m[i] && (c < wid(cur_bm[i]));
            end
            if (c == P - 1) begin
                for (int i = 0; i < NCH; i++) begin
                    en_m[i]   = ce[i];
                    cur_am[i] = slew_to(cur_am[i], tgt_m[i], 0);
                    cur_bm[i] = slew_to(cur_bm[i], tgt_m[i], SLEW_B);
                end
            end
            if (we && wc < NCH) tgt_m[wc] = wp;
            k++;
        end
        for (int i = 0; i < NCH; i++) begin
            set_a[i] = (cur_am[i] == tgt_m[i]);
            set_b[i] = (cur_bm[i] == tgt_m[i]);
            cp_a[i*POS_W +: POS_W] = POS_W'(cur_am[i]);
            cp_b[i*POS_W +: POS_W] = POS_W'(cur_bm[i]);
        end
        check("cycle_a", {fs_a, servo_a, settled_a, cur_a}, {efs, es_a, set_a, cp_a});
        check("cycle_b", {fs_b, servo_b, settled_b, cur_b}, {efs, es_b, set_b, cp_b});
        for (int i = 0; i < NCH; i++) begin
            if (fs_a) last_len_a[i] = 0;
            if (fs_b) last_len_b[i] = 0;
            if (servo_a[i]) hi_len_a[i]++;
            else if (hi_len_a[i] > 0) begin last_len_a[i] = hi_len_a[i]; hi_len_a[i] = 0; end
            if (servo_b[i]) hi_len_b[i]++;
            else if (hi_len_b[i] > 0) begin last_len_b[i] = hi_len_b[i]; hi_len_b[i] = 0; end
        end
    endtask

    // Advance until the next edge sees ctr == t (at least one clock).
    task automatic run_to(input int t);
        step();
        while (k % P != t) step();
    endtask

    logic [NCH*POS_W-1:0] all_init;

    initial begin
        all_init = {NCH{8'd128}};
        rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_pos = '0; ch_en = '1;
        repeat (3) step();
        check("reset_servo", servo_a, 0);
        check("reset_fs", fs_a, 0);
        check("reset_cur", cur_a, all_init);
        rst = 1'b0;

        // Idle frames at the initial position
        step();
        check("first_frame_start", fs_a, 1);
        run_to(P - 1);
        check("first_frame_low", last_len_a[0], 0);
        run_to(P - 1);
        check("idle_width_ch0", last_len_a[0], 740);
        check("idle_width_ch4", last_len_b[4], 740);
        run_to(P - 1);
        check("idle_settled", settled_a, 5'h1f);
        check("idle_cur", cur_b, all_init);

        // Mid-frame writes, including an out-of-range channel
        run_to(100);
        wr_en = 1'b1; wr_ch = 3'd0; wr_pos = 8'd0;   step();
        wr_ch = 3'd1; wr_pos = 8'd255;               step();
        wr_ch = 3'd7; wr_pos = 8'd3;                 step();
        wr_en = 1'b0;
        run_to(P - 1);
        check("midwrite_keep_ch0", last_len_a[0], 740);
        check("midwrite_keep_ch1", last_len_a[1], 740);
        run_to(P - 1);
        check("newwidth_ch0", last_len_a[0], 100);
        check("newwidth_ch1", last_len_a[1], 1375);
        check("untouched_ch2", last_len_a[2], 740);
        check("untouched_ch3", last_len_a[3], 740);
        check("untouched_ch4", last_len_a[4], 740);

        // Slew-limited approach 128 -> 255 on ch4 of the slew-16 instance
        run_to(200);
        wr_en = 1'b1; wr_ch = 3'd4; wr_pos = 8'd255; step();
        wr_en = 1'b0;
        for (int f = 0; f < 8; f++) begin
            run_to(1);
            check("slew_cur_ch4", cur_b[4*POS_W +: POS_W], (f < 7) ? 144 + 16 * f : 255);
            check("slew_settled_ch4", settled_b[4], (f == 7) ? 1 : 0);
            if (f == 0) check("jump_cur_ch4", cur_a[4*POS_W +: POS_W], 255);
        end

        // Write on the boundary clock itself
        run_to(P - 1);
        wr_en = 1'b1; wr_ch = 3'd2; wr_pos = 8'd0; step();
        wr_en = 1'b0;
        run_to(P - 1);
        check("boundary_write_old", last_len_a[2], 740);
        run_to(P - 1);
        check("boundary_write_new", last_len_a[2], 100);

        // Enable dropped mid-pulse, then restored
        run_to(500);
        ch_en[3] = 1'b0;
        run_to(P - 1);
        check("disable_pulse_completes", last_len_a[3], 740);
        run_to(P - 1);
        check("disabled_frame_low", last_len_a[3], 0);
        ch_en[3] = 1'b1;
        run_to(P - 1);
        check("reenabled_width", last_len_a[3], 740);

        // Single-clock reset while pulses are high
        run_to(300);
        rst = 1'b1; step(); rst = 1'b0;
        check("midreset_servo_a", servo_a, 0);
        check("midreset_servo_b", servo_b, 0);
        check("midreset_fs", fs_a, 0);
        check("midreset_cur_a", cur_a, all_init);
        check("midreset_cur_b", cur_b, all_init);
        run_to(P - 1);
        check("post_reset_low_ch1", last_len_a[1], 0);
        check("post_reset_low_ch3", last_len_b[3], 0);
        run_to(P - 1);
        check("post_reset_width_ch0", last_len_a[0], 740);
        check("post_reset_width_ch1", last_len_b[1], 740);

        // Random writes and enable changes against the model
        for (int f = 0; f < 6; f++) begin
            for (int c = 0; c < P; c++) begin
                if ($urandom_range(63) == 0) begin
                    wr_en = 1'b1; wr_ch = CH_W'($urandom_range(7)); wr_pos = POS_W'($urandom);
                end else begin
                    wr_en = 1'b0;
                end
                if ($urandom_range(499) == 0) ch_en = NCH'($urandom);
                step();
            end
        end
        wr_en = 1'b0; ch_en = '1;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
